// File: rtl/bio_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bio_rr_arbiter
//  Purpose  : Burst-oriented round-robin arbiter sharing one valid/ready beat
//             port among NREQ requesters, with a sticky stall-timeout flag.
//  Revision : 1.0 - initial release
// ============================================================================
module bio_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int MAXHOLD = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    output logic                    out_last,
    output logic [$clog2(NREQ)-1:0] out_src,
    input  logic                    out_ready,
    output logic                    timeout_err,
    input  logic                    err_clr
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAXHOLD + 1);
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam int unsigned c_nreq = NREQ;
    localparam logic [BW-1:0] c_hold_last  = BW'(MAXHOLD - 1);
    localparam logic [SW-1:0] c_stall_last = SW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_gnt, w_gnt_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [BW-1:0] r_beat_cnt, w_beat_nxt;
    logic [SW-1:0] r_stall_cnt, w_stall_nxt;
    logic          r_timeout_err;
    logic          w_err_set;
    logic          w_release;

    logic [IW-1:0] w_pick;
    logic          w_any;
    logic          w_sel_valid;
    logic          w_sel_last;
    logic [DW-1:0] w_sel_data;

    // (idx + off) modulo NREQ; NREQ need not be a power of two
    function automatic logic [IW-1:0] f_wrap_inc(input logic [IW-1:0] idx,
                                                 input int unsigned   off);
        int unsigned s;
        s = 32'(idx) + off;
        if (s >= c_nreq) s = s - c_nreq;
        return s[IW-1:0];
    endfunction

    // Scan from the highest offset down so the nearest index after ptr wins
    always_comb begin
        w_pick = r_ptr;
        w_any  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[f_wrap_inc(r_ptr, unsigned'(k))]) begin
                w_pick = f_wrap_inc(r_ptr, unsigned'(k));
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt == IW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_beat_nxt  = r_beat_cnt;
        w_stall_nxt = r_stall_cnt;
        w_err_set   = 1'b0;
        w_release   = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = w_sel_data;
        req_ready   = '0;

        case (r_state)
            ST_IDLE: begin
                w_stall_nxt = '0;
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_pick;
                    w_beat_nxt  = '0;
                end
            end
            ST_GRANT: begin
                out_valid = w_sel_valid;
                out_last  = w_sel_last;
                for (int i = 0; i < NREQ; i++) begin
                    req_ready[i] = (r_gnt == IW'(i)) & out_ready;
                end
                if (!w_sel_valid) begin
                    w_release = 1'b1;
                end else if (out_ready) begin
                    w_beat_nxt  = r_beat_cnt + BW'(1);
                    w_stall_nxt = '0;
                    if (w_sel_last || (r_beat_cnt == c_hold_last)) w_release = 1'b1;
                end else if (r_stall_cnt == c_stall_last) begin
                    // stalled beat is abandoned, not accepted
                    w_release = 1'b1;
                    w_err_set = 1'b1;
                end else begin
                    w_stall_nxt = r_stall_cnt + SW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_release) begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = f_wrap_inc(r_gnt, 1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_gnt         <= '0;
            r_ptr         <= '0;
            r_beat_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_ptr         <= w_ptr_nxt;
            r_beat_cnt    <= w_beat_nxt;
            r_stall_cnt   <= w_stall_nxt;
            r_timeout_err <= w_err_set | (r_timeout_err & ~err_clr);
        end
    end

    assign out_src     = r_gnt;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_bio_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bio_rr_arbiter
//  Purpose  : Directed self-checking bench for bio_rr_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bio_rr_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int MAXHOLD = 8;
    localparam int TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic                 out_last;
    logic [1:0]           out_src;
    logic                 out_ready;
    logic                 timeout_err;
    logic                 err_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bio_rr_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .MAXHOLD (MAXHOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_src     (out_src),
        .out_ready   (out_ready),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;

        // reset values
        cyc(); settle();
        chk("rst_out_valid", 64'(out_valid),   64'd0);
        chk("rst_req_ready", 64'(req_ready),   64'd0);
        chk("rst_out_last",  64'(out_last),    64'd0);
        chk("rst_out_src",   64'(out_src),     64'd0);
        chk("rst_err",       64'(timeout_err), 64'd0);
        resetn = 1'b1;

        // single requester 2, 3-beat burst
        cyc(); req_valid = 4'b0100; set_data(2, 32'hA0); out_ready = 1'b1; settle();
        chk("t1_idle_valid", 64'(out_valid), 64'd0);
        chk("t1_idle_ready", 64'(req_ready), 64'd0);
        for (int b = 0; b < 3; b++) begin
            cyc(); set_data(2, 32'hA0 + 32'(b)); req_last = (b == 2) ? 4'b0100 : 4'b0000; settle();
            chk("t1_src",   64'(out_src),   64'd2);
            chk("t1_valid", 64'(out_valid), 64'd1);
            chk("t1_data",  64'(out_data),  64'(32'hA0 + 32'(b)));
            chk("t1_ready", 64'(req_ready), 64'b0100);
            chk("t1_last",  64'(out_last),  (b == 2) ? 64'd1 : 64'd0);
        end
        cyc(); req_valid = 4'b1111; req_last = '0; settle();
        chk("t1_bubble",   64'(out_valid), 64'd0);
        chk("t1_src_hold", 64'(out_src),   64'd2);
        chk("t1_bub_last", 64'(out_last),  64'd0);
        cyc(); req_valid = '0; settle();
        chk("t1_ptr_next", 64'(out_src),   64'd3);
        chk("t1_novalid",  64'(out_valid), 64'd0);

        // requesters 0 and 1 alternate 2-beat bursts
        cyc(); req_valid = 4'b0011; settle();
        chk("t2_idle", 64'(out_valid), 64'd0);
        for (int n = 0; n < 4; n++) begin
            cyc(); req_last = '0; set_data(n % 2, 32'hB000 + 32'(n * 2)); settle();
            chk("t2_src",   64'(out_src),   64'(n % 2));
            chk("t2_valid", 64'(out_valid), 64'd1);
            chk("t2_ready", 64'(req_ready), (n % 2 == 0) ? 64'b0001 : 64'b0010);
            cyc(); req_last = '0; req_last[n % 2] = 1'b1; set_data(n % 2, 32'hB001 + 32'(n * 2)); settle();
            chk("t2_last",  64'(out_last),  64'd1);
            chk("t2_data",  64'(out_data),  64'(32'hB001 + 32'(n * 2)));
            cyc(); req_last = '0; if (n == 3) req_valid = '0; settle();
            chk("t2_bubble", 64'(out_valid), 64'd0);
        end

        // requester 3 with no last: MAXHOLD cut, wrap, regrant
        cyc(); req_valid = 4'b1000; req_last = '0; settle();
        chk("t3_idle", 64'(out_valid), 64'd0);
        for (int b = 0; b < MAXHOLD; b++) begin
            cyc(); set_data(3, 32'hC0 + 32'(b)); settle();
            chk("t3_valid", 64'(out_valid), 64'd1);
            chk("t3_src",   64'(out_src),   64'd3);
            chk("t3_ready", 64'(req_ready), 64'b1000);
        end
        cyc(); settle();
        chk("t3_hold_release", 64'(out_valid), 64'd0);
        chk("t3_hold_ready",   64'(req_ready), 64'd0);
        cyc(); req_last = 4'b1000; settle();
        chk("t3_regrant_src",   64'(out_src),   64'd3);
        chk("t3_regrant_valid", 64'(out_valid), 64'd1);
        cyc(); req_valid = 4'b1001; req_last = '0; settle();
        chk("t3_last_release", 64'(out_valid), 64'd0);
        cyc(); req_last = 4'b0001; settle();
        chk("t3_wrap_src",   64'(out_src),   64'd0);
        chk("t3_wrap_valid", 64'(out_valid), 64'd1);
        cyc(); req_valid = '0; req_last = '0; settle();
        chk("t3_done", 64'(out_valid), 64'd0);

        // requester 1 stalled until timeout, then err_clr
        cyc(); req_valid = 4'b0010; out_ready = 1'b0; settle();
        chk("t4_idle", 64'(out_valid), 64'd0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            cyc(); settle();
            chk("t4_stall_valid", 64'(out_valid),   64'd1);
            chk("t4_stall_ready", 64'(req_ready),   64'd0);
            chk("t4_stall_err",   64'(timeout_err), 64'd0);
        end
        cyc(); req_valid = '0; settle();
        chk("t4_released", 64'(out_valid),   64'd0);
        chk("t4_err_set",  64'(timeout_err), 64'd1);
        cyc(); err_clr = 1'b1; settle();
        chk("t4_err_held", 64'(timeout_err), 64'd1);
        cyc(); err_clr = 1'b0; settle();
        chk("t4_err_clr", 64'(timeout_err), 64'd0);

        // timeout coincident with err_clr
        cyc(); req_valid = 4'b0010; settle();
        chk("t5_idle", 64'(out_valid), 64'd0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            cyc(); err_clr = (k == TIMEOUT); settle();
            chk("t5_stall_valid", 64'(out_valid), 64'd1);
        end
        cyc(); err_clr = 1'b0; req_valid = '0; settle();
        chk("t5_set_wins", 64'(timeout_err), 64'd1);
        chk("t5_released", 64'(out_valid),   64'd0);
        cyc(); err_clr = 1'b1; settle();
        cyc(); err_clr = 1'b0; settle();
        chk("t5_err_clr", 64'(timeout_err), 64'd0);

        // async reset mid-burst; ptr restarts at 0
        cyc(); req_valid = 4'b0100; out_ready = 1'b1; req_last = '0; settle();
        cyc(); set_data(2, 32'hD0); settle();
        chk("t6_beat1_src", 64'(out_src), 64'd2);
        cyc(); set_data(2, 32'hD1); resetn = 1'b0; settle();
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_ready", 64'(req_ready), 64'd0);
        chk("t6_rst_src",   64'(out_src),   64'd0);
        #2; resetn = 1'b1; req_valid = 4'b0110;
        cyc(); settle();
        chk("t6_post_src",   64'(out_src),   64'd1);
        chk("t6_post_ready", 64'(req_ready), 64'b0010);
        req_valid = '0;
        cyc(); settle();
        chk("t6_post_done", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
